// File: rtl/countdown_matrix.sv
// countdown_matrix: countdown responder for the start/over handshake.
// Loads a 0..7 start value on a rising edge of the count request, counts it down
// in TICK_DIV-cycle steps, and scans the remaining value onto an 8x8 red/green
// dot matrix. Raises over at zero and holds it until the request is withdrawn.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_cst    count request (level): high = run/hold result, low = abort/release
//   i_dzst   matrix enable (level)
//   i_num    start value, sampled only at load
//   o_row    row select, one-hot active-low
//   o_colr   red columns, active-high, bit 7 = leftmost
//   o_colg   green columns, active-high, bit 7 = leftmost
//   o_over   count finished (level)
module countdown_matrix #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned SCAN_DIV = 1_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cst,
  input  logic       i_dzst,
  input  logic [2:0] i_num,
  output logic [7:0] o_row,
  output logic [7:0] o_colr,
  output logic [7:0] o_colg,
  output logic       o_over
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] ScanMax = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    SelSmiley = 4'd8;

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e        r_state, w_state_d;
  logic [2:0]    r_rem, w_rem_d;
  logic [TW-1:0] r_tick, w_tick_d;
  logic [SW-1:0] r_presc;
  logic [2:0]    r_scan;
  logic          r_cst_q;
  // Set once cst has been seen low after reset, so a request already high when
  // reset is released does not count as an edge.
  logic          r_armed;
  logic          w_edge;

  logic [3:0]    w_sel;
  logic [63:0]   w_bits;
  logic [7:0]    w_line;
  logic [7:0]    w_row_d, w_colr_d, w_colg_d;
  logic          w_over_d;

  // Glyph rows packed row 0 in the top byte.
  function automatic logic [63:0] glyph(input logic [3:0] sel);
    logic [63:0] g;
    case (sel)
      4'd0:    g = 64'h3C666E7666663C00;
      4'd1:    g = 64'h183818181818_7E00;
      4'd2:    g = 64'h3C66060C30607E00;
      4'd3:    g = 64'h3C66061C06663C00;
      4'd4:    g = 64'h0C1C3C6C7E0C0C00;
      4'd5:    g = 64'h7E607C0606663C00;
      4'd6:    g = 64'h3C607C6666663C00;
      4'd7:    g = 64'h7E060C1830303000;
      4'd8:    g = 64'h3C42A581A599423C;
      default: g = 64'h0;
    endcase
    return g;
  endfunction

  assign w_edge = i_cst & ~r_cst_q & r_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_rem   <= '0;
      r_tick  <= '0;
      r_cst_q <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_rem   <= w_rem_d;
      r_tick  <= w_tick_d;
      r_cst_q <= i_cst;
      r_armed <= r_armed | ~i_cst;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_rem_d   = r_rem;
    w_tick_d  = r_tick;
    case (r_state)
      StIdle: begin
        if (w_edge) begin
          w_rem_d   = i_num;
          w_tick_d  = '0;
          w_state_d = (i_num != 3'd0) ? StCount : StDone;
        end
      end
      StCount: begin
        // Abort wins over a coincident tick.
        if (!i_cst) begin
          w_state_d = StIdle;
          w_tick_d  = '0;
        end else if (r_tick == TickMax) begin
          w_tick_d = '0;
          w_rem_d  = r_rem - 3'd1;
          if (r_rem == 3'd1) w_state_d = StDone;
        end else begin
          w_tick_d = r_tick + 1'b1;
        end
      end
      StDone: begin
        w_rem_d = '0;
        if (!i_cst) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Row scan runs independently of the countdown.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_scan  <= '0;
    end else if (r_presc == ScanMax) begin
      r_presc <= '0;
      r_scan  <= r_scan + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    case (r_state)
      StIdle:  w_sel = SelSmiley;
      StCount: w_sel = {1'b0, r_rem};
      default: w_sel = 4'd0;
    endcase
    w_bits = glyph(w_sel);
    w_line = w_bits[{3'd7 - r_scan, 3'b000} +: 8];

    w_row_d  = 8'hFF;
    w_colr_d = 8'h00;
    w_colg_d = 8'h00;
    if (i_dzst) begin
      w_row_d = ~(8'd1 << r_scan);
      if (r_state == StCount) w_colr_d = w_line;
      else                    w_colg_d = w_line;
    end
    w_over_d = (r_state == StDone);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_row  <= 8'hFF;
      o_colr <= 8'h00;
      o_colg <= 8'h00;
      o_over <= 1'b0;
    end else begin
      o_row  <= w_row_d;
      o_colr <= w_colr_d;
      o_colg <= w_colg_d;
      o_over <= w_over_d;
    end
  end

endmodule

// File: tb/tb_countdown_matrix.sv
module tb_countdown_matrix;

  localparam int unsigned TickDiv = 10;
  localparam int unsigned ScanDiv = 2;

  // Display modes for expected-value generation.
  localparam int ModeIdle  = 0;
  localparam int ModeCount = 1;
  localparam int ModeDone  = 2;
  localparam int ModeOff   = 3;

  localparam int SigRow  = 0;
  localparam int SigColr = 1;
  localparam int SigColg = 2;
  localparam int SigOver = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cst;
  logic       dzst;
  logic [2:0] num;
  logic [7:0] row, colr, colg;
  logic       over;

  always #5 clk = ~clk;

  countdown_matrix #(
    .TICK_DIV (TickDiv),
    .SCAN_DIV (ScanDiv)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_cst   (cst),
    .i_dzst  (dzst),
    .i_num   (num),
    .o_row   (row),
    .o_colr  (colr),
    .o_colg  (colg),
    .o_over  (over)
  );

  typedef struct {
    int         due;
    string      tag;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gline(input int sel, input int r);
    logic [63:0] g;
    case (sel)
      0:       g = 64'h3C666E7666663C00;
      1:       g = 64'h1838181818187E00;
      2:       g = 64'h3C66060C30607E00;
      3:       g = 64'h3C66061C06663C00;
      4:       g = 64'h0C1C3C6C7E0C0C00;
      5:       g = 64'h7E607C0606663C00;
      6:       g = 64'h3C607C6666663C00;
      7:       g = 64'h7E060C1830303000;
      default: g = 64'h3C42A581A599423C;
    endcase
    return g[8*(7-r) +: 8];
  endfunction

  function automatic void push(input int due, input string tag, input int sig,
                               input logic [7:0] exp);
    exp_t e;
    int   i;
    e.due = due;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    i = 0;
    while (i < sb.size() && sb[i].due <= due) i++;
    sb.insert(i, e);
  endfunction

  // Output at cycle c (counted from reset release) shows scan row ((c-1)/2)%8.
  function automatic void push_disp(input int c, input int mode, input int dig);
    int         idx;
    logic [7:0] r_exp, cr_exp, cg_exp;
    idx    = ((c - 1) / int'(ScanDiv)) % 8;
    r_exp  = ~(8'd1 << idx);
    cr_exp = 8'h00;
    cg_exp = 8'h00;
    case (mode)
      ModeIdle:  cg_exp = gline(8, idx);
      ModeCount: cr_exp = gline(dig, idx);
      ModeDone:  cg_exp = gline(0, idx);
      default:   r_exp  = 8'hFF;
    endcase
    push(c, $sformatf("row@%0d", c), SigRow, r_exp);
    push(c, $sformatf("colr@%0d", c), SigColr, cr_exp);
    push(c, $sformatf("colg@%0d", c), SigColg, cg_exp);
  endfunction

  function automatic void push_over(input int c, input logic v);
    push(c, $sformatf("over@%0d", c), SigOver, {7'd0, v});
  endfunction

  // Expected display for a countdown with start value 3 loaded at edge e.
  function automatic void push_count3(input int e, input int last);
    for (int c = e + 2; c <= last; c++) begin
      if (c <= e + 11)      push_disp(c, ModeCount, 3);
      else if (c <= e + 21) push_disp(c, ModeCount, 2);
      else if (c <= e + 31) push_disp(c, ModeCount, 1);
      else                  push_disp(c, ModeDone, 0);
    end
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.sig)
        SigRow:  check_eq(mon_e.tag, row, mon_e.exp);
        SigColr: check_eq(mon_e.tag, colr, mon_e.exp);
        SigColg: check_eq(mon_e.tag, colg, mon_e.exp);
        default: check_eq(mon_e.tag, {7'd0, over}, mon_e.exp);
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_row"}, row, 8'hFF);
    check_eq({tag, "_colr"}, colr, 8'h00);
    check_eq({tag, "_colg"}, colg, 8'h00);
    check_eq({tag, "_over"}, {7'd0, over}, 8'h00);
  endtask

  int e0, f0, e2;

  initial begin
    rst_n = 1'b0;
    cst   = 1'b0;
    dzst  = 1'b1;
    num   = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc   = 0;

    // Idle smiley scan over more than one frame, then matrix disabled briefly.
    for (int c = 1; c <= 18; c++) push_disp(c, ModeIdle, 0);
    push_over(9, 1'b0);
    step(18);
    dzst = 1'b0;
    for (int c = 19; c <= 22; c++) push_disp(c, ModeOff, 0);
    push_disp(23, ModeIdle, 0);
    push_disp(24, ModeIdle, 0);
    step(4);
    dzst = 1'b1;
    step(4);

    // Full countdown from 3, held result, then release.
    e0  = cyc;
    num = 3'd3;
    cst = 1'b1;
    push_count3(e0, e0 + 47);
    push_over(e0 + 31, 1'b0);
    push_over(e0 + 32, 1'b1);
    push_over(e0 + 45, 1'b1);
    step(48);
    f0  = cyc;
    cst = 1'b0;
    push_over(f0 + 1, 1'b1);
    push_over(f0 + 2, 1'b0);
    push_disp(f0 + 2, ModeIdle, 0);
    step(4);

    // Abort mid-count, then restart with 1.
    e0  = cyc;
    num = 3'd3;
    cst = 1'b1;
    push_count3(e0, e0 + 16);
    for (int c = e0 + 17; c <= e0 + 21; c++) push_disp(c, ModeIdle, 0);
    push_over(e0 + 16, 1'b0);
    push_over(e0 + 20, 1'b0);
    step(15);
    cst = 1'b0;
    step(5);
    e2  = cyc;
    num = 3'd1;
    cst = 1'b1;
    for (int c = e2 + 2; c <= e2 + 11; c++) push_disp(c, ModeCount, 1);
    push_disp(e2 + 12, ModeDone, 0);
    push_over(e2 + 11, 1'b0);
    push_over(e2 + 12, 1'b1);
    step(14);
    f0  = cyc;
    cst = 1'b0;
    push_over(f0 + 2, 1'b0);
    step(4);

    // Start value 0: immediate finish, then release.
    e0  = cyc;
    num = 3'd0;
    cst = 1'b1;
    push_over(e0 + 1, 1'b0);
    push_over(e0 + 2, 1'b1);
    push_disp(e0 + 2, ModeDone, 0);
    step(5);
    f0  = cyc;
    cst = 1'b0;
    push_over(f0 + 1, 1'b1);
    push_over(f0 + 2, 1'b0);
    step(4);

    // num changes after load are ignored.
    e0  = cyc;
    num = 3'd3;
    cst = 1'b1;
    push_count3(e0, e0 + 33);
    push_over(e0 + 31, 1'b0);
    push_over(e0 + 32, 1'b1);
    step(5);
    num = 3'd7;
    step(29);
    cst = 1'b0;
    step(4);

    // Asynchronous reset mid-count with cst held high through release.
    e0  = cyc;
    num = 3'd3;
    cst = 1'b1;
    push_count3(e0, e0 + 24);
    step(25);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    num = 3'd1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 1; c <= 24; c++) push_disp(c, ModeIdle, 0);
    push_over(13, 1'b0);
    push_over(24, 1'b0);
    step(25);
    cst = 1'b0;
    step(3);
    e2  = cyc;
    cst = 1'b1;
    push_over(e2 + 11, 1'b0);
    push_over(e2 + 12, 1'b1);
    step(14);
    cst = 1'b0;
    step(3);

    check_eq("sb_empty", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_matrix.md
# countdown_matrix

Countdown responder for the game controller's start/over handshake. It holds a level-sensitive count request, counts down from a loaded value in whole-second steps, and scans the remaining value onto the 8x8 red/green dot matrix. It raises `over` when the count reaches zero and holds it until the controller withdraws the request. It sits beside the random-number, beeper and seven-segment blocks under the game top level and is its only driver of `row`, `colr` and `colg`.

## Interface
- `TICK_DIV`, default 1_000_000: clk cycles per countdown step (1 s at 1 MHz).
- `SCAN_DIV`, default 1_000: clk cycles per matrix row.
- `clk`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cst`  in  1  count request, level; high = run or hold result, low = abort or release.
- `dzst`  in  1  matrix enable, level.
- `num`  in  3  start value 0..7, sampled only at load.
- `row`  out  8  row select, one-hot active-low.
- `colr`  out  8  red columns, active-high; bit 7 = leftmost.
- `colg`  out  8  green columns, active-high; bit 7 = leftmost.
- `over`  out  1  count finished, level.

## Operation
- Registers:
  - 3-bit `rem` (remaining count).
  - Tick counter, 0..TICK_DIV-1.
  - Scan prescaler, 0..SCAN_DIV-1.
  - 3-bit scan index `r`.
  - `cst_q` (previous `cst`).
- States: IDLE, COUNT, DONE.
- IDLE:
  - `over`=0.
  - When `cst` is high and `cst_q` is low (rising edge): `rem`<=`num`, tick<=0.
  - Go to COUNT if `num`!=0, else to DONE.
  - A `cst` that is already high on leaving reset is not an edge; the block waits for low then high.
- COUNT:
  - Tick increments each cycle.
  - When tick == TICK_DIV-1: tick<=0 and `rem`<=`rem`-1.
  - If `rem` was 1, go to DONE.
  - `cst` low in any cycle: go to IDLE at once, tick cleared. Abort has priority over the tick.
- DONE:
  - `over`=1.
  - `rem`=0.
  - Stays until `cst` is low, then goes to IDLE with `over`=0.
- `num` changes after load are ignored.
- Scan:
  - Runs continuously regardless of state.
  - Prescaler wraps at SCAN_DIV-1 and advances `r`; `r` wraps 7->0.
- Display content, applied to glyph row `r`:
  - `dzst`=0: `row`=FF, `colr`=00, `colg`=00.
  - IDLE with `dzst`=1: smiley in green, red off.
  - COUNT: digit `rem` in red, green off.
  - DONE: digit 0 in green, red off.
  - When lit, `row` = ~(1<<r) and the column byte is glyph row `r`.
- Glyph rows 0..7, hex, MSB = leftmost:
  - smiley 3C 42 A5 81 A5 99 42 3C
  - 0: 3C 66 6E 76 66 66 3C 00
  - 1: 18 38 18 18 18 18 7E 00
  - 2: 3C 66 06 0C 30 60 7E 00
  - 3: 3C 66 06 1C 06 66 3C 00
  - 4: 0C 1C 3C 6C 7E 0C 0C 00
  - 5: 7E 60 7C 06 06 66 3C 00
  - 6: 3C 60 7C 66 66 66 3C 00
  - 7: 7E 06 0C 18 30 30 30 00

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE.
  - `rem`, tick, prescaler, `r` and `cst_q` all 0.
  - `row`=FF, `colr`=00, `colg`=00, `over`=0.
- All outputs are registered. They reflect state, `rem` and `r` with 1 cycle latency.
- Edge at cycle E (first cycle `cst`=1 with `cst_q`=0):
  - State is COUNT from E+1.
  - `rem` decrements at E+TICK_DIV, E+2·TICK_DIV, and so on.
  - With N=`num`: state DONE from E+N·TICK_DIV+1, `over` high from E+N·TICK_DIV+2.
  - `num`=0: DONE at E+1, `over` high at E+2.
- `cst` low at cycle F while in DONE: IDLE at F+1, `over` low at F+2.
- Abort at cycle F in COUNT: IDLE at F+1. `over` never asserts.
- A new rising edge after abort or release reloads `num` and restarts the tick from 0.
- Row `r` is held for exactly SCAN_DIV cycles. A full frame is 8·SCAN_DIV cycles.
- `rst_n` asserted mid-count: all registers return to reset values immediately, with no glitch on `over`.

## Test plan
All scenarios use TICK_DIV=10, SCAN_DIV=2.
1. Reset released, `dzst`=1, `cst`=0 -> `row` cycles FE,FD,...,7F at 2 cycles per row; `colg` = 3C,42,A5,81,A5,99,42,3C; `colr`=00.
2. `num`=3, `cst` rises at cycle E -> `rem` 3→2→1→0 at E+10, E+20, E+30; `over`=1 at E+32 and held; `colg`=3C on row 0 in DONE.
3. `num`=3, `cst` dropped at E+15 -> IDLE at E+16, `over` stays 0; re-raise with `num`=1 -> `over`=1 exactly 12 cycles after the new edge.
4. `num`=0 edge -> `over`=1 two cycles later; `cst` low -> `over`=0 two cycles later.
5. `num` changed 3→7 at E+5 -> countdown still ends at E+32; in COUNT at `rem`=2, row 0 shows `colr`=3C, `colg`=00.
6. `rst_n` pulsed low at E+25 -> outputs FF/00/00/0 asynchronously; `cst` held high through release -> no restart until `cst` goes low then high.
